// File: rtl/sync_rx_fifo_if.sv
// Handshake bundle between the receive FIFO and the synchronizer/consumer pair.
// The master modport is the driving side (synchronizer, consumer and bench); the slave modport is the FIFO.
interface sync_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] sync_bus;
  logic                  enable_pulse;
  logic                  rd_ready;
  logic                  clr_overflow;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  full;
  logic [CW-1:0]         count;
  logic                  overflow;

  modport master (
    output sync_bus, enable_pulse, rd_ready, clr_overflow,
    input  rd_data, rd_valid, empty, full, count, overflow
  );

  modport slave (
    input  sync_bus, enable_pulse, rd_ready, clr_overflow,
    output rd_data, rd_valid, empty, full, count, overflow
  );
endinterface

// File: rtl/sync_rx_fifo.sv
// Show-ahead receive FIFO that captures synchronized words on enable_pulse
// and hands them to the consumer over valid/ready, with a sticky overflow flag.
module sync_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic           clk,
  input  logic           rst,
  sync_rx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]           r_wrPtr;
  logic [AW:0]           r_rdPtr;
  logic                  r_overflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_write;
  logic                  w_drop;
  logic [AW:0]           w_count;

  // Extra pointer MSB tells a full ring from an empty one when the addresses match.
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) && (r_wrPtr[AW] != r_rdPtr[AW]);
  assign w_count = r_wrPtr - r_rdPtr;

  assign w_pop   = !w_empty && bus.rd_ready;
  assign w_write = bus.enable_pulse && (!w_full || w_pop);
  assign w_drop  = bus.enable_pulse && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_write) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)   r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Storage is deliberately left unreset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wrPtr[AW-1:0]] <= bus.sync_bus;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_overflow <= 1'b0;
    else if (w_drop)           r_overflow <= 1'b1;
    else if (bus.clr_overflow) r_overflow <= 1'b0;
  end

  assign bus.rd_data  = w_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];
  assign bus.rd_valid = !w_empty;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.count    = w_count;
  assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_sync_rx_fifo.sv
// Directed bench for sync_rx_fifo: reset sequence, vector table, then a streaming wrap run.
module tb_sync_rx_fifo;
  typedef struct {
    logic       en;
    logic [7:0] data;
    logic       rdy;
    logic       clr;
    logic       expValid;
    logic [7:0] expData;
    logic [3:0] expCount;
    logic       expFull;
    logic       expOvf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  sync_rx_fifo_if #(.DATA_WIDTH(8), .DEPTH(8)) fifoIf ();

  sync_rx_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fifoIf.slave)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic en, input logic [7:0] data,
                               input logic rdy, input logic clr);
    fifoIf.enable_pulse = en;
    fifoIf.sync_bus     = data;
    fifoIf.rd_ready     = rdy;
    fifoIf.clr_overflow = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic expValid, input logic [7:0] expData,
                             input logic [3:0] expCount, input logic expFull, input logic expOvf);
    logic [15:0] act;
    logic [15:0] exp;
    act = {fifoIf.rd_valid, fifoIf.empty, fifoIf.full, fifoIf.overflow, fifoIf.count, fifoIf.rd_data};
    exp = {expValid, !expValid, expFull, expOvf, expCount, expData};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got valid/empty/full/ovf/count/data=%b%b%b%b/%0d/%02h want %b%b%b%b/%0d/%02h",
               name, act[15], act[14], act[13], act[12], act[11:8], act[7:0],
               exp[15], exp[14], exp[13], exp[12], exp[11:8], exp[7:0]);
    end
  endtask

  task automatic addVec(input logic en, input logic [7:0] data, input logic rdy, input logic clr,
                        input logic v, input logic [7:0] d, input logic [3:0] c,
                        input logic f, input logic o);
    vec_t x;
    x.en = en; x.data = data; x.rdy = rdy; x.clr = clr;
    x.expValid = v; x.expData = d; x.expCount = c; x.expFull = f; x.expOvf = o;
    vecs.push_back(x);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Single transfer then pop
    addVec(1, 8'hAA, 0, 0, 1, 8'hAA, 1, 0, 0);
    addVec(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
    // Fill with 01..08, then 09 is dropped
    for (int i = 1; i <= 8; i++)
      addVec(1, 8'(i), 0, 0, 1, 8'h01, 4'(i), (i == 8), 0);
    addVec(1, 8'h09, 0, 0, 1, 8'h01, 8, 1, 1);
    for (int i = 1; i <= 8; i++)
      addVec(0, 8'h00, 1, 0, (i < 8), (i < 8) ? 8'(i + 1) : 8'h00, 4'(8 - i), 0, 1);
    addVec(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0);
    // Full with simultaneous write and pop
    for (int i = 0; i < 8; i++)
      addVec(1, 8'(8'h10 + i), 0, 0, 1, 8'h10, 4'(i + 1), (i == 7), 0);
    addVec(1, 8'h18, 1, 0, 1, 8'h11, 8, 1, 0);
    for (int i = 1; i <= 8; i++)
      addVec(0, 8'h00, 1, 0, (i < 8), (i < 8) ? 8'(8'h11 + i) : 8'h00, 4'(8 - i), 0, 0);
    // Empty with simultaneous write and ready: no pop in the write cycle
    addVec(1, 8'h5C, 1, 0, 1, 8'h5C, 1, 0, 0);
    addVec(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);

    fifoIf.enable_pulse = 0;
    fifoIf.sync_bus     = 0;
    fifoIf.rd_ready     = 0;
    fifoIf.clr_overflow = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Asynchronous reset with three words stored
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'hE0 + i), 0, 0);
    checkOutput("preReset", 1, 8'hE0, 3, 0, 0);
    fifoIf.enable_pulse = 0;
    #2 rst = 1'b1;
    #1 checkOutput("asyncReset", 0, 8'h00, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].en, vecs[k].data, vecs[k].rdy, vecs[k].clr);
      checkOutput($sformatf("vec%0d", k), vecs[k].expValid, vecs[k].expData,
                  vecs[k].expCount, vecs[k].expFull, vecs[k].expOvf);
    end

    // Streaming: each word is popped the cycle after it lands, wrapping pointers twice
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 8'(i), 1, 0);
      checkOutput($sformatf("stream%0d", i), 1, 8'(i), 1, 0, 0);
    end
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("streamDrain", 0, 8'h00, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
